// File: rtl/enc83_scan.sv
// Sequential priority encoder: accepts a request vector and emits the
// index of every set bit, one beat per handshake.
module enc83_scan #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IW       = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_none,
  output logic [IW:0]   out_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] pending;
  logic [IW-1:0] pidx;
  logic [IW:0]  pcnt;
  logic         fire;

  always_comb begin
    pidx = '0;
    if (LSB_FIRST) begin
      for (int i = W - 1; i >= 0; i--)
        if (pending[i]) pidx = IW'(i);
    end else begin
      for (int i = 0; i < W; i++)
        if (pending[i]) pidx = IW'(i);
    end
  end

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < W; i++)
      pcnt = pcnt + (IW+1)'(in_vec[i]);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_idx   = pidx;
  // at most one bit left in pending means this beat is the final one
  assign out_last  = out_valid &&
                     ((pending & (pending - W'(1))) == '0);
  assign fire      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_none  <= 1'b0;
      out_count <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (in_valid) begin
            pending   <= in_vec;
            out_count <= pcnt;
            out_none  <= (in_vec == '0);
            state     <= SCAN;
          end
        end
        (state == SCAN): begin
          if (fire) begin
            pending[pidx] <= 1'b0;
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc83_scan.sv
// Randomized self-checking bench for enc83_scan, both scan orders
// run side by side on shared stimulus.
module tb_enc83_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = '0;
  logic       out_ready = 1'b0;

  logic       ir_a, ov_a, ol_a, on_a;
  logic [2:0] oi_a;
  logic [3:0] oc_a;
  logic       ir_b, ov_b, ol_b, on_b;
  logic [2:0] oi_b;
  logic [3:0] oc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc83_scan #(.W(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_a), .in_vec(in_vec),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_idx(oi_a), .out_last(ol_a), .out_none(on_a),
    .out_count(oc_a)
  );

  enc83_scan #(.W(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_b), .in_vec(in_vec),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_idx(oi_b), .out_last(ol_b), .out_none(on_b),
    .out_count(oc_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready_a"}, 32'(ir_a), 1);
    chk({tag, " valid_a"}, 32'(ov_a), 0);
    chk({tag, " ready_b"}, 32'(ir_b), 1);
    chk({tag, " valid_b"}, 32'(ov_b), 0);
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge.
  // mode: 0 always ready, 1 ready 1,0,0 pattern, 2 random ready.
  task automatic run_vec(input logic [7:0] v, input int mode,
                         input bit hold);
    int lsb[$];
    int msb[$];
    int nb, beats, cyc, pop;
    bit none;
    lsb = {};
    msb = {};
    for (int i = 0; i < 8; i++)
      if (v[i]) lsb.push_back(i);
    pop = lsb.size();
    none = (pop == 0);
    if (none) lsb.push_back(0);
    for (int i = lsb.size() - 1; i >= 0; i--)
      msb.push_back(lsb[i]);
    nb = lsb.size();

    chk_idle("pre");
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    in_valid = hold;
    in_vec   = 8'($urandom);
    beats = 0;
    cyc = 0;
    while (beats < nb && cyc < 200) begin
      unique case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      chk("valid_a", 32'(ov_a), 1);
      chk("valid_b", 32'(ov_b), 1);
      chk("inready_a", 32'(ir_a), 0);
      chk("inready_b", 32'(ir_b), 0);
      chk("idx_a", 32'(oi_a), 32'(lsb[beats]));
      chk("idx_b", 32'(oi_b), 32'(msb[beats]));
      chk("last_a", 32'(ol_a), 32'(beats == nb - 1));
      chk("last_b", 32'(ol_b), 32'(beats == nb - 1));
      chk("none_a", 32'(on_a), 32'(none));
      chk("none_b", 32'(on_b), 32'(none));
      chk("count_a", 32'(oc_a), 32'(pop));
      chk("count_b", 32'(oc_b), 32'(pop));
      @(negedge clk);
      if (out_ready) beats++;
      cyc++;
    end
    if (beats < nb) chk("beat_budget", 32'(beats), 32'(nb));
    out_ready = 1'b0;
    chk_idle("post");
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst idx_a", 32'(oi_a), 0);
    chk("rst last_a", 32'(ol_a), 0);
    chk("rst none_a", 32'(on_a), 0);
    chk("rst count_a", 32'(oc_a), 0);
    chk("rst idx_b", 32'(oi_b), 0);
    chk("rst count_b", 32'(oc_b), 0);
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while scanning drops the pending vector
    in_valid = 1'b1;
    in_vec = 8'b1010_0110;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("pre_rst idx_a", 32'(oi_a), 1);
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid_a", 32'(ov_a), 0);
    chk("midrst ready_a", 32'(ir_a), 1);
    chk("midrst valid_b", 32'(ov_b), 0);
    chk("midrst ready_b", 32'(ir_b), 1);
    chk("midrst count_a", 32'(oc_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(8'h01, 0, 1'b0);

    run_vec(8'b1010_0110, 0, 1'b0);
    run_vec(8'h00, 0, 1'b0);
    run_vec(8'h80, 0, 1'b0);
    run_vec(8'hFF, 1, 1'b0);
    for (int k = 0; k < 6; k++)
      run_vec((k % 2 == 0) ? 8'h03 : 8'h40, 0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 40; k++)
      run_vec(8'($urandom), $urandom_range(0, 2),
              1'($urandom));
    in_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
